// File: rtl/aes_pkg.sv
// Shared AES definitions: walk states, round count, Rcon table and the
// GF(2^8) arithmetic used by the InvMixColumns key transform.
package aes_pkg;

    localparam int NUM_ROUNDS = 10;

    // Walk states; any other encoding is treated as idle
    typedef enum logic [2:0] {
        s_IDLE      = 3'b000,
        s_ROUND10   = 3'b001,
        s_ROUND9to1 = 3'b010,
        s_ROUND0    = 3'b011
    } state_e;

    // Round constant for the round being left; 0 outside 1..10
    function automatic logic [7:0] rcon(input logic [3:0] round);
        logic [7:0] value;
        case (round)
            4'd1:    value = 8'h01;
            4'd2:    value = 8'h02;
            4'd3:    value = 8'h04;
            4'd4:    value = 8'h08;
            4'd5:    value = 8'h10;
            4'd6:    value = 8'h20;
            4'd7:    value = 8'h40;
            4'd8:    value = 8'h80;
            4'd9:    value = 8'h1b;
            4'd10:   value = 8'h36;
            default: value = 8'h00;
        endcase
        return value;
    endfunction

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Multiply by a small constant (InvMixColumns only needs 4-bit factors)
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [3:0] b);
        logic [7:0] acc;
        logic [7:0] pwr;
        acc = 8'h00;
        pwr = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) begin
                acc = acc ^ pwr;
            end
            pwr = xtime(pwr);
        end
        return acc;
    endfunction

    // InvMixColumns on one column, first byte in the MSBs
    function automatic logic [31:0] inv_mix_word(input logic [31:0] w);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] b0, b1, b2, b3;
        a0 = w[31:24];
        a1 = w[23:16];
        a2 = w[15:8];
        a3 = w[7:0];
        b0 = gf_mul(a0, 4'he) ^ gf_mul(a1, 4'hb) ^ gf_mul(a2, 4'hd) ^ gf_mul(a3, 4'h9);
        b1 = gf_mul(a0, 4'h9) ^ gf_mul(a1, 4'he) ^ gf_mul(a2, 4'hb) ^ gf_mul(a3, 4'hd);
        b2 = gf_mul(a0, 4'hd) ^ gf_mul(a1, 4'h9) ^ gf_mul(a2, 4'he) ^ gf_mul(a3, 4'hb);
        b3 = gf_mul(a0, 4'hb) ^ gf_mul(a1, 4'hd) ^ gf_mul(a2, 4'h9) ^ gf_mul(a3, 4'he);
        return {b0, b1, b2, b3};
    endfunction

endpackage

// File: rtl/aes_sub_word.sv
// SubWord: four independent AES S-box lookups on a 32-bit word.
// Purely combinational; shared with the forward key expansion.
module aes_sub_word (
    input  logic [31:0] word_i,
    output logic [31:0] word_o
);

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Substitute each byte of the word through the S-box
    always_comb begin
        word_o = '0;
        for (int i = 0; i < 4; i++) begin
            word_o[8*i +: 8] = SBOX[word_i[8*i +: 8]];
        end
    end

endmodule

// File: rtl/aes_inv_key_expand.sv
// Reverse-order AES-128 key schedule: takes the round-10 key and emits
// round keys 10 down to 0 on consecutive cycles for the inverse cipher.
// Optional build macro AES_INV_MIXCOL_KEY_EN: rounds 9..1 are emitted with
// InvMixColumns applied per word (equivalent inverse cipher). The internal
// key register always holds the plain key, so the backward walk is unaffected.
module aes_inv_key_expand
    import aes_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  dv_in,
    input  logic [DATA_WIDTH-1:0] key_in_0,
    input  logic [DATA_WIDTH-1:0] key_in_1,
    input  logic [DATA_WIDTH-1:0] key_in_2,
    input  logic [DATA_WIDTH-1:0] key_in_3,
    output logic                  busy_out,
    output logic                  dv_out,
    output logic [3:0]            round_out,
    output logic [DATA_WIDTH-1:0] key_out_0,
    output logic [DATA_WIDTH-1:0] key_out_1,
    output logic [DATA_WIDTH-1:0] key_out_2,
    output logic [DATA_WIDTH-1:0] key_out_3,
    output logic                  done_out
);

    state_e                state_q;
    logic [3:0]            cnt_q;
    logic [DATA_WIDTH-1:0] key_q [4];

    logic                  busy_q;
    logic                  dv_q;
    logic                  done_q;
    logic [3:0]            round_q;
    logic [DATA_WIDTH-1:0] out_key_q [4];

    logic [DATA_WIDTH-1:0] key0_d;
    logic [DATA_WIDTH-1:0] key1_d;
    logic [DATA_WIDTH-1:0] key2_d;
    logic [DATA_WIDTH-1:0] key3_d;
    logic [DATA_WIDTH-1:0] rot_word;
    logic [DATA_WIDTH-1:0] sub_word;
    logic [DATA_WIDTH-1:0] out_d [4];

    // Upper three words of the previous round key are plain XORs of neighbours
    always_comb begin
        key3_d = key_q[3] ^ key_q[2];
        key2_d = key_q[2] ^ key_q[1];
        key1_d = key_q[1] ^ key_q[0];
    end

    assign rot_word = {key3_d[DATA_WIDTH-9:0], key3_d[DATA_WIDTH-1:DATA_WIDTH-8]};

    aes_sub_word u_sub_word (
        .word_i (rot_word),
        .word_o (sub_word)
    );

    // Word 0 of the previous key undoes the g() function, using Rcon of the round being left
    always_comb begin
        key0_d = key_q[0] ^ sub_word ^ {rcon(cnt_q), 24'h000000};
    end

    // Output-path view of the stepped key for the middle rounds
    always_comb begin
`ifdef AES_INV_MIXCOL_KEY_EN
        out_d[0] = inv_mix_word(key0_d);
        out_d[1] = inv_mix_word(key1_d);
        out_d[2] = inv_mix_word(key2_d);
        out_d[3] = inv_mix_word(key3_d);
`else
        out_d[0] = key0_d;
        out_d[1] = key1_d;
        out_d[2] = key2_d;
        out_d[3] = key3_d;
`endif
    end

    // Walk FSM with key register, round counter and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= s_IDLE;
            cnt_q   <= 4'd0;
            busy_q  <= 1'b0;
            dv_q    <= 1'b0;
            done_q  <= 1'b0;
            round_q <= 4'd0;
            for (int i = 0; i < 4; i++) begin
                key_q[i]     <= '0;
                out_key_q[i] <= '0;
            end
        end else begin
            case (state_q)
                s_IDLE: begin
                    busy_q <= 1'b0;
                    dv_q   <= 1'b0;
                    done_q <= 1'b0;
                    if (dv_in) begin
                        key_q[0] <= key_in_0;
                        key_q[1] <= key_in_1;
                        key_q[2] <= key_in_2;
                        key_q[3] <= key_in_3;
                        cnt_q    <= 4'(NUM_ROUNDS);
                        state_q  <= s_ROUND10;
                    end
                end
                s_ROUND10: begin
                    busy_q  <= 1'b1;
                    dv_q    <= 1'b1;
                    done_q  <= 1'b0;
                    round_q <= 4'(NUM_ROUNDS);
                    for (int i = 0; i < 4; i++) begin
                        out_key_q[i] <= key_q[i];
                    end
                    state_q <= s_ROUND9to1;
                end
                s_ROUND9to1: begin
                    if (cnt_q > 4'(NUM_ROUNDS) || cnt_q < 4'd2) begin
                        busy_q  <= 1'b0;
                        dv_q    <= 1'b0;
                        done_q  <= 1'b0;
                        state_q <= s_IDLE;
                    end else begin
                        busy_q   <= 1'b1;
                        dv_q     <= 1'b1;
                        done_q   <= 1'b0;
                        key_q[0] <= key0_d;
                        key_q[1] <= key1_d;
                        key_q[2] <= key2_d;
                        key_q[3] <= key3_d;
                        for (int i = 0; i < 4; i++) begin
                            out_key_q[i] <= out_d[i];
                        end
                        cnt_q   <= cnt_q - 4'd1;
                        round_q <= cnt_q - 4'd1;
                        if (cnt_q == 4'd2) begin
                            state_q <= s_ROUND0;
                        end
                    end
                end
                s_ROUND0: begin
                    if (cnt_q != 4'd1) begin
                        busy_q <= 1'b0;
                        dv_q   <= 1'b0;
                        done_q <= 1'b0;
                    end else begin
                        busy_q       <= 1'b1;
                        dv_q         <= 1'b1;
                        done_q       <= 1'b1;
                        round_q      <= 4'd0;
                        key_q[0]     <= key0_d;
                        key_q[1]     <= key1_d;
                        key_q[2]     <= key2_d;
                        key_q[3]     <= key3_d;
                        out_key_q[0] <= key0_d;
                        out_key_q[1] <= key1_d;
                        out_key_q[2] <= key2_d;
                        out_key_q[3] <= key3_d;
                    end
                    cnt_q   <= 4'd0;
                    state_q <= s_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    dv_q    <= 1'b0;
                    done_q  <= 1'b0;
                    cnt_q   <= 4'd0;
                    state_q <= s_IDLE;
                end
            endcase
        end
    end

    assign busy_out  = busy_q;
    assign dv_out    = dv_q;
    assign done_out  = done_q;
    assign round_out = round_q;
    assign key_out_0 = out_key_q[0];
    assign key_out_1 = out_key_q[1];
    assign key_out_2 = out_key_q[2];
    assign key_out_3 = out_key_q[3];

endmodule

// File: tb/tb_aes_inv_key_expand.sv
// Testbench for aes_inv_key_expand. The reference builds the S-box from the
// GF(2^8) inverse plus affine map and runs the forward FIPS-197 expansion;
// the DUT is fed w40..w43 and must return the schedule in reverse order.
module tb_aes_inv_key_expand;

    logic        clk;
    logic        rst_n;
    logic        dv_in;
    logic [31:0] key_in_0, key_in_1, key_in_2, key_in_3;
    logic        busy_out, dv_out, done_out;
    logic [3:0]  round_out;
    logic [31:0] key_out_0, key_out_1, key_out_2, key_out_3;

    int totalChecks = 0;
    int passChecks  = 0;

    logic [7:0]   sboxRef [256];
    logic [31:0]  wRef [44];
    logic [127:0] gotKey [11];

    typedef struct {
        int           round;
        logic [127:0] key;
    } fipsVec_t;

    fipsVec_t fipsTable [4];

    localparam logic [127:0] FIPS_K0 = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    aes_inv_key_expand #(.DATA_WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .dv_in     (dv_in),
        .key_in_0  (key_in_0),
        .key_in_1  (key_in_1),
        .key_in_2  (key_in_2),
        .key_in_3  (key_in_3),
        .busy_out  (busy_out),
        .dv_out    (dv_out),
        .round_out (round_out),
        .key_out_0 (key_out_0),
        .key_out_1 (key_out_1),
        .key_out_2 (key_out_2),
        .key_out_3 (key_out_3),
        .done_out  (done_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] refXtime(input logic [7:0] a);
        return (a << 1) ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] refGmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ p;
            p = refXtime(p);
        end
        return acc;
    endfunction

    function automatic logic [7:0] refRotl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [31:0] refSubWord(input logic [31:0] w);
        return {sboxRef[w[31:24]], sboxRef[w[23:16]], sboxRef[w[15:8]], sboxRef[w[7:0]]};
    endfunction

    function automatic logic [31:0] refInvMixWord(input logic [31:0] w);
        logic [7:0] a [4];
        logic [7:0] b [4];
        for (int i = 0; i < 4; i++) a[i] = w[31-8*i -: 8];
        for (int i = 0; i < 4; i++) begin
            b[i] = refGmul(a[i], 8'h0e) ^ refGmul(a[(i+1)%4], 8'h0b)
                 ^ refGmul(a[(i+2)%4], 8'h0d) ^ refGmul(a[(i+3)%4], 8'h09);
        end
        return {b[0], b[1], b[2], b[3]};
    endfunction

    // Round keys 1..9 are seen through InvMixColumns when the option is built in
    function automatic logic [127:0] outputView(input int r, input logic [127:0] k);
`ifdef AES_INV_MIXCOL_KEY_EN
        if (r >= 1 && r <= 9) begin
            return {refInvMixWord(k[127:96]), refInvMixWord(k[95:64]),
                    refInvMixWord(k[63:32]), refInvMixWord(k[31:0])};
        end
`endif
        return k;
    endfunction

    function automatic logic [127:0] expectedRound(input int r);
        return outputView(r, {wRef[4*r], wRef[4*r+1], wRef[4*r+2], wRef[4*r+3]});
    endfunction

    task automatic buildSbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            if (x != 0) begin
                for (int y = 1; y < 256; y++) begin
                    if (refGmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
                end
            end
            sboxRef[x] = inv ^ refRotl(inv, 1) ^ refRotl(inv, 2) ^ refRotl(inv, 3)
                       ^ refRotl(inv, 4) ^ 8'h63;
        end
    endtask

    // Forward FIPS-197 key expansion into wRef[0..43]
    task automatic expandRef(input logic [127:0] k0);
        logic [31:0] temp;
        logic [7:0]  rc;
        wRef[0] = k0[127:96];
        wRef[1] = k0[95:64];
        wRef[2] = k0[63:32];
        wRef[3] = k0[31:0];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            temp = wRef[i-1];
            if (i % 4 == 0) begin
                temp = refSubWord({temp[23:0], temp[31:24]}) ^ {rc, 24'h000000};
                rc = refXtime(rc);
            end
            wRef[i] = wRef[i-4] ^ temp;
        end
    endtask

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        totalChecks++;
        if (actual === expected) begin
            passChecks++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Start a walk from the given cipher key and check every cycle of it.
    // holdHigh keeps dv_in asserted so a second walk follows; glitch pokes
    // dv_in with a different key while round 7 is shown and while the block
    // is producing its round-0 output.
    task automatic applyStimulus(input string tag, input logic [127:0] cipherKey,
                                 input int numWalks, input bit holdHigh, input bit glitch);
        logic [127:0] k10;
        int phase;
        int r;
        int lastCycle;
        expandRef(cipherKey);
        k10 = {wRef[40], wRef[41], wRef[42], wRef[43]};
        @(negedge clk);
        dv_in = 1'b1;
        {key_in_0, key_in_1, key_in_2, key_in_3} = k10;
        @(negedge clk);
        if (!holdHigh) dv_in = 1'b0;
        checkOutput({tag, "_dv_after_start"}, 128'({dv_out, busy_out}), 128'(2'b00));
        lastCycle = 12 * numWalks + 2;
        for (int c = 1; c <= lastCycle; c++) begin
            @(negedge clk);
            phase = (c - 1) % 12;
            if ((c - 1) < 12 * numWalks && phase < 11) begin
                r = 10 - phase;
                checkOutput($sformatf("%s_c%0d_ctrl", tag, c),
                            128'({dv_out, busy_out, done_out, round_out}),
                            128'({1'b1, 1'b1, (r == 0), 4'(r)}));
                gotKey[r] = {key_out_0, key_out_1, key_out_2, key_out_3};
                if (r == 0) begin
                    for (int rr = 0; rr <= 10; rr++) begin
                        checkOutput($sformatf("%s_round%0d_key", tag, rr), gotKey[rr], expectedRound(rr));
                    end
                end
            end else begin
                checkOutput($sformatf("%s_c%0d_idle", tag, c),
                            128'({dv_out, busy_out, done_out}), 128'(3'b000));
            end
            if (glitch) begin
                if (c == 3 || c == 10) begin
                    dv_in = 1'b1;
                    {key_in_0, key_in_1, key_in_2, key_in_3} = ~k10;
                end else if (c == 4 || c == 11) begin
                    dv_in = 1'b0;
                end
            end
            if (holdHigh && c == 13) dv_in = 1'b0;
        end
    endtask

    initial begin
        logic [127:0] k10;

        fipsTable[0] = '{10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        fipsTable[1] = '{9,  128'hac7766f319fadc2128d12941575c006e};
        fipsTable[2] = '{1,  128'ha0fafe1788542cb123a339392a6c7605};
        fipsTable[3] = '{0,  128'h2b7e151628aed2a6abf7158809cf4f3c};

        buildSbox();

        rst_n = 1'b0;
        dv_in = 1'b0;
        {key_in_0, key_in_1, key_in_2, key_in_3} = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset_ctrl", 128'({busy_out, dv_out, done_out, round_out}), 128'(0));
        checkOutput("reset_key", {key_out_0, key_out_1, key_out_2, key_out_3}, 128'(0));
        rst_n = 1'b1;

        $display("[TB] FIPS-197 walk");
        applyStimulus("fips", FIPS_K0, 1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("fips_table_round%0d", fipsTable[i].round),
                        gotKey[fipsTable[i].round],
                        outputView(fipsTable[i].round, fipsTable[i].key));
        end

        $display("[TB] dv_in pulses while busy");
        applyStimulus("glitch", FIPS_K0, 1, 1'b0, 1'b1);

        $display("[TB] reset during round 5");
        expandRef(FIPS_K0);
        k10 = {wRef[40], wRef[41], wRef[42], wRef[43]};
        @(negedge clk);
        dv_in = 1'b1;
        {key_in_0, key_in_1, key_in_2, key_in_3} = k10;
        @(negedge clk);
        dv_in = 1'b0;
        repeat (6) @(negedge clk);
        checkOutput("midwalk_round5", 128'(round_out), 128'(4'd5));
        rst_n = 1'b0;
        #1;
        checkOutput("midwalk_reset_ctrl", 128'({busy_out, dv_out, done_out, round_out}), 128'(0));
        checkOutput("midwalk_reset_key", {key_out_0, key_out_1, key_out_2, key_out_3}, 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("after_reset_idle", 128'({busy_out, dv_out}), 128'(0));
        applyStimulus("restart", FIPS_K0, 1, 1'b0, 1'b0);

        $display("[TB] back-to-back with dv_in held high");
        applyStimulus("b2b", {$urandom, $urandom, $urandom, $urandom}, 2, 1'b1, 1'b0);

        $display("[TB] random cipher keys");
        for (int n = 0; n < 4; n++) begin
            applyStimulus($sformatf("rand%0d", n), {$urandom, $urandom, $urandom, $urandom}, 1, 1'b0, 1'b0);
        end

        $display("%0d/%0d checks passed", passChecks, totalChecks);
        $finish;
    end

endmodule

// File: doc/aes_inv_key_expand.md
Name: aes_inv_key_expand

Overview:
- Reverse-order AES-128 key schedule generator for the decryption datapath.
- Accepts the round-10 key as four 32-bit words and walks the schedule backwards to the cipher key.
- Emits round keys 10, 9, …, 0 on consecutive cycles, one round key per cycle, in the order the inverse cipher consumes them.
- Sits between the key-load interface and the inverse round core; it is the counterpart of the forward key expansion.

Parameters:
DATA_WIDTH, 32, width of one key word; fixed at 32 for AES-128, other values unsupported.

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
dv_in  input  1  start pulse; key_in_* valid this cycle
key_in_0  input  DATA_WIDTH  round-10 key word w40 (MSB = first byte)
key_in_1  input  DATA_WIDTH  word w41
key_in_2  input  DATA_WIDTH  word w42
key_in_3  input  DATA_WIDTH  word w43
busy_out  output  1  high while a schedule walk is in progress
dv_out  output  1  key_out_* and round_out valid
round_out  output  4  round index of current output key, 10 down to 0
key_out_0  output  DATA_WIDTH  round key word 0
key_out_1  output  DATA_WIDTH  round key word 1
key_out_2  output  DATA_WIDTH  round key word 2
key_out_3  output  DATA_WIDTH  round key word 3
done_out  output  1  one-cycle pulse coincident with the round-0 output

Behaviour:
- Reset values (asynchronous): state IDLE; all key registers 0; round counter 0; busy_out=0, dv_out=0, done_out=0, round_out=0, key_out_*=0.
- All outputs are registered.
- State machine:
  - s_IDLE: when dv_in=1, capture key_in_* into the key register, load the counter with 10, go to s_ROUND10. dv_in=0 → stay.
  - s_ROUND10: dv_out=1, round_out=10, key_out = captured key. Go to s_ROUND9to1.
  - s_ROUND9to1: each cycle, key register ← inverse step; counter decrements. Outputs rounds 9..1 with dv_out=1. When the counter reaches 1, go to s_ROUND0.
  - s_ROUND0: outputs round 0 with dv_out=1 and done_out=1. Go to s_IDLE.
- Latency: dv_in sampled at edge N gives round 10 valid after edge N+1 and round 0 valid after edge N+11. dv_out is high for 11 consecutive cycles.
- Inverse step: current key k0..k3 at round r (1..10) produces previous key p0..p3:
  - p3 = k3^k2
  - p2 = k2^k1
  - p1 = k1^k0
  - p0 = k0 ^ SubWord(RotWord(p3)) ^ {Rcon[r],24'h0}
  - Rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36
- The counter indexes Rcon with the round being left, i.e. r of the current register contents.
- busy_out=1 in every state other than s_IDLE.
- dv_in while busy: ignored, with no capture and no restart. dv_in in the cycle that s_ROUND0 is output: ignored. A new start is accepted only once the block is back in s_IDLE.
- Reset mid-walk: immediate return to reset values; the partial sequence is abandoned.
- Unused counter/state encodings go to s_IDLE.

Optional Feature:
- AES_INV_MIXCOL_KEY_EN defined:
  - Round keys 9..1 are output after InvMixColumns is applied per word, for the equivalent inverse cipher.
  - Rounds 10 and 0 are output unmodified.
  - The transform is applied on the output path only. The internal key register always holds the untransformed key, so the inverse step is unaffected.
  - Output latency is unchanged; the transform is combinational ahead of the output register.
- AES_INV_MIXCOL_KEY_EN undefined: all eleven round keys are output unmodified.

Decomposition:
- Shared package aes_pkg:
  - Rcon table
  - state encodings: s_IDLE=3'b000, s_ROUND10=3'b001, s_ROUND9to1=3'b010, s_ROUND0=3'b011
  - round-count constants NUM_ROUNDS=10
  - GF(2^8) xtime/multiply functions, used by InvMixColumns
- Sub-module aes_sub_word: four S-box byte lookups on a 32-bit word, shared with the forward key expansion.

Test Plan:
- FIPS-197 A.1: dv_in with key_in = d014f9a8 c9ee2589 e13f0cc8 b6630ca6 → dv_out asserted 11 cycles in a row; key sequence includes:
  - round 9 = ac7766f3 19fadc21 28d12941 575c006e
  - round 1 = a0fafe17 88542cb1 23a33939 2a6c7605
  - round 0 = 2b7e1516 28aed2a6 abf71588 09cf4f3c, with done_out=1
- Timing: dv_in at edge N → round_out=10 after edge N+1, round_out=0 after edge N+11; busy_out falls the cycle after done_out.
- dv_in pulsed with different key_in during rounds 7 and 0 → ignored; output sequence identical to the first test.
- rst_n asserted during round 5 → all outputs 0 immediately; a new dv_in after release restarts cleanly at round 10.
- Back-to-back: dv_in held high continuously → a new walk starts only from s_IDLE; exactly one idle cycle between done_out and the next round-10 output.
- With AES_INV_MIXCOL_KEY_EN: round 10 and round 0 match the first test; rounds 9..1 equal the reference-model InvMixColumns of those keys.
